// File: rtl/priority_irq_ctrl_if.sv
// Request/acknowledge bundle between an interrupt source block and the priority controller.
// The master side drives requests, masks and acknowledges; the slave side presents the selected index.
interface priority_irq_ctrl_if #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
);
  logic [N-1:0]    req;
  logic [N-1:0]    mask;
  logic            irq_ack;
  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]    pending;

  modport master (
    output req, mask, irq_ack,
    input  irq_valid, irq_id, pending
  );

  modport slave (
    input  req, mask, irq_ack,
    output irq_valid, irq_id, pending
  );
endinterface

// File: rtl/priority_irq_ctrl.sv
// Edge-capturing interrupt controller: posts requests on rising req edges and presents one index at a time.
// Selection is fixed priority (highest index) or round-robin starting after the last acknowledged channel.
module priority_irq_ctrl #(
  parameter int N       = 8,
  parameter int ID_W    = $clog2(N),
  parameter int RR_MODE = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  priority_irq_ctrl_if.slave  bus
);

  logic [N-1:0]    req_d_q, req_d_d;
  logic [N-1:0]    pending_q, pending_d;
  logic            irq_valid_q, irq_valid_d;
  logic [ID_W-1:0] irq_id_q, irq_id_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic [N-1:0]    rise;
  logic [N-1:0]    cand;
  logic [ID_W-1:0] sel_id;
  logic            sel_found;
  int              rr_idx;
  logic            ack_fire;

  assign rise     = bus.req & ~req_d_q;
  assign cand     = pending_q & ~bus.mask;
  assign ack_fire = irq_valid_q & bus.irq_ack;

  // Round-robin walks ptr+1 upward with an explicit modulo so non-power-of-two N wraps to 0.
  always_comb begin
    sel_id    = '0;
    sel_found = 1'b0;
    rr_idx    = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= N; k++) begin
        rr_idx = (int'(ptr_q) + k) % N;
        if (!sel_found && cand[rr_idx]) begin
          sel_found = 1'b1;
          sel_id    = ID_W'(rr_idx);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          sel_found = 1'b1;
          sel_id    = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    req_d_d     = bus.req;
    pending_d   = pending_q;
    irq_valid_d = irq_valid_q;
    irq_id_d    = irq_id_q;
    ptr_d       = ptr_q;

    // Clear before set so a fresh edge on the acknowledged channel survives.
    if (ack_fire) begin
      pending_d[irq_id_q] = 1'b0;
      irq_valid_d         = 1'b0;
      if (RR_MODE != 0) begin
        ptr_d = irq_id_q;
      end
    end else if (!irq_valid_q && sel_found) begin
      irq_valid_d = 1'b1;
      irq_id_d    = sel_id;
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d_q     <= '0;
      pending_q   <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      ptr_q       <= ID_W'(N - 1);
    end else begin
      req_d_q     <= req_d_d;
      pending_q   <= pending_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.irq_valid = irq_valid_q;
  assign bus.irq_id    = irq_id_q;
  assign bus.pending   = pending_q;

endmodule

// File: tb/tb_priority_irq_ctrl.sv
// Directed bench: a fixed-priority N=8 controller and a round-robin N=5 controller sharing clock and reset.
module tb_priority_irq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  priority_irq_ctrl_if #(.N(8), .ID_W(3)) f_if ();
  priority_irq_ctrl_if #(.N(5), .ID_W(3)) r_if ();

  priority_irq_ctrl #(.N(8), .ID_W(3), .RR_MODE(0)) u_fixed (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (f_if.slave)
  );

  priority_irq_ctrl #(.N(5), .ID_W(3), .RR_MODE(1)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (r_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int rr_exp [6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    f_if.req     = '0;
    f_if.mask    = '0;
    f_if.irq_ack = 1'b0;
    r_if.req     = '0;
    r_if.mask    = '0;
    r_if.irq_ack = 1'b0;

    repeat (2) @(negedge clk);
    check_output("rst_f_valid", f_if.irq_valid, 0);
    check_output("rst_f_id", f_if.irq_id, 0);
    check_output("rst_f_pending", f_if.pending, 0);
    check_output("rst_r_valid", r_if.irq_valid, 0);
    check_output("rst_r_pending", r_if.pending, 0);

    // Two simultaneous rising edges, highest index first.
    rst_n    = 1'b1;
    f_if.req = 8'h24;
    @(negedge clk);
    check_output("a_pending_k", f_if.pending, 8'h24);
    check_output("a_valid_k", f_if.irq_valid, 0);
    @(negedge clk);
    check_output("a_valid_k1", f_if.irq_valid, 1);
    check_output("a_id_5", f_if.irq_id, 5);
    f_if.irq_ack = 1'b1;
    @(negedge clk);
    check_output("a_valid_gap", f_if.irq_valid, 0);
    check_output("a_pending_after_ack", f_if.pending, 8'h04);
    f_if.irq_ack = 1'b0;
    @(negedge clk);
    check_output("a_valid_2", f_if.irq_valid, 1);
    check_output("a_id_2", f_if.irq_id, 2);
    check_output("a_held_no_repost", f_if.pending, 8'h04);

    // Higher-priority arrival must not preempt the presented index.
    f_if.req = 8'hA4;
    @(negedge clk);
    check_output("b_id_hold1", f_if.irq_id, 2);
    check_output("b_valid_hold1", f_if.irq_valid, 1);
    check_output("b_pending", f_if.pending, 8'h84);
    @(negedge clk);
    check_output("b_id_hold2", f_if.irq_id, 2);
    f_if.irq_ack = 1'b1;
    @(negedge clk);
    check_output("b_idle_gap", f_if.irq_valid, 0);
    check_output("b_pending_after_ack", f_if.pending, 8'h80);
    f_if.irq_ack = 1'b0;
    @(negedge clk);
    check_output("b_valid_7", f_if.irq_valid, 1);
    check_output("b_id_7", f_if.irq_id, 7);
    f_if.irq_ack = 1'b1;
    @(negedge clk);
    check_output("b_cleared", f_if.pending, 0);
    f_if.irq_ack = 1'b0;
    f_if.req     = '0;

    // Masked pending bit is retained but not presented.
    @(negedge clk);
    f_if.req  = 8'h08;
    f_if.mask = 8'h08;
    @(negedge clk);
    check_output("c_pending", f_if.pending, 8'h08);
    check_output("c_valid_masked1", f_if.irq_valid, 0);
    @(negedge clk);
    check_output("c_valid_masked2", f_if.irq_valid, 0);
    check_output("c_pending_kept", f_if.pending, 8'h08);
    f_if.mask = '0;
    @(negedge clk);
    check_output("c_valid_unmask", f_if.irq_valid, 1);
    check_output("c_id_3", f_if.irq_id, 3);

    // Fresh edge on channel 3 coinciding with its acknowledge.
    f_if.req = '0;
    @(negedge clk);
    check_output("d_id_hold", f_if.irq_id, 3);
    f_if.req     = 8'h08;
    f_if.irq_ack = 1'b1;
    @(negedge clk);
    check_output("d_valid_gap", f_if.irq_valid, 0);
    check_output("d_pending_set_wins", f_if.pending, 8'h08);
    f_if.irq_ack = 1'b0;
    @(negedge clk);
    check_output("d_valid_again", f_if.irq_valid, 1);
    check_output("d_id_3_again", f_if.irq_id, 3);
    f_if.irq_ack = 1'b1;
    @(negedge clk);
    check_output("d_cleared", f_if.pending, 0);
    f_if.irq_ack = 1'b0;
    f_if.req     = 8'h81;

    // Reset while presenting discards everything; held req reposts after release.
    @(negedge clk);
    check_output("e_pending", f_if.pending, 8'h81);
    @(negedge clk);
    check_output("e_valid", f_if.irq_valid, 1);
    check_output("e_id_7", f_if.irq_id, 7);
    #2 rst_n = 1'b0;
    #1;
    check_output("e_rst_valid", f_if.irq_valid, 0);
    check_output("e_rst_id", f_if.irq_id, 0);
    check_output("e_rst_pending", f_if.pending, 0);
    @(negedge clk);
    check_output("e_rst_hold_pending", f_if.pending, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("e_repost", f_if.pending, 8'h81);
    check_output("e_repost_valid", f_if.irq_valid, 0);
    @(negedge clk);
    check_output("e_repost_id", f_if.irq_id, 7);

    // Round-robin over five channels, including the wrap from 4 back to 0.
    r_if.req = 5'h1F;
    @(negedge clk);
    check_output("r_pending", r_if.pending, 5'h1F);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check_output($sformatf("r_valid_%0d", i), r_if.irq_valid, 1);
      check_output($sformatf("r_id_%0d", i), r_if.irq_id, rr_exp[i]);
      r_if.irq_ack = 1'b1;
      if (i == 0) r_if.req = 5'h1E;
      @(negedge clk);
      check_output($sformatf("r_gap_%0d", i), r_if.irq_valid, 0);
      r_if.irq_ack = 1'b0;
      if (i == 0) r_if.req = 5'h1F;
      if (i < 5) @(negedge clk);
    end
    check_output("r_pending_done", r_if.pending, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
